// File: rtl/vga_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_ctrl
// Brief    : 800x600 VGA test-pattern colour stage (bars, checker, bouncing
//            box, border) with frame-synchronous mode switching.
// Revision : 1.0
// ============================================================================
module vga_pattern_ctrl #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [10:0] column_addr,
    input  logic [10:0] row_addr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        mode_btn,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [11:0] c_h_last = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_v_last = 12'(V_ACTIVE - 1);
    localparam logic [11:0] c_size   = 12'(BOX_SIZE);
    localparam logic [11:0] c_step   = 12'(BOX_STEP);
    localparam logic [11:0] c_x_lim  = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] c_y_lim  = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] c_bar_w  = 12'(H_ACTIVE / 8);

    localparam logic [1:0] c_mode_bars   = 2'd0;
    localparam logic [1:0] c_mode_check  = 2'd1;
    localparam logic [1:0] c_mode_box    = 2'd2;
    localparam logic [1:0] c_mode_border = 2'd3;

    // Returns {direction (1 = negative), next position} for one box axis.
    function automatic logic [11:0] f_axis(
        input logic [10:0] pos,
        input logic        dir_neg,
        input logic [11:0] lim
    );
        logic [11:0] w_pos;
        logic [11:0] w_res;
        w_pos = {1'b0, pos};
        if (!dir_neg) begin
            if ((w_pos + c_step) >= lim) w_res = {1'b1, lim[10:0]};
            else                         w_res = {1'b0, pos + c_step[10:0]};
        end else begin
            if (w_pos <= c_step) w_res = 12'd0;
            else                 w_res = {1'b1, pos - c_step[10:0]};
        end
        return w_res;
    endfunction

    // Mode and box state
    logic [1:0]  mode_pend_q, mode_pend_d;
    logic [1:0]  mode_act_q,  mode_act_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    // Stage 1
    logic        ready_s1_q, ready_s1_d;
    logic [2:0]  cls_s1_q,   cls_s1_d;
    logic        hs_s1_q,    hs_s1_d;
    logic        vs_s1_q,    vs_s1_d;

    // Stage 2
    logic [4:0]  red_q,   red_d;
    logic [5:0]  green_q, green_d;
    logic [4:0]  blue_q,  blue_d;
    logic        hs_s2_q, hs_s2_d;
    logic        vs_s2_q, vs_s2_d;

    logic        w_tick;
    logic [11:0] w_col;
    logic [11:0] w_row;
    logic [2:0]  w_bar_idx;
    logic [2:0]  w_bar_cls;
    logic        w_in_box;
    logic        w_on_border;
    logic [11:0] w_x_next;
    logic [11:0] w_y_next;

    // The stage-1 vsync register doubles as the edge detector's history bit.
    always_comb begin
        w_tick   = vs_s1_q & ~vsync_in;
        w_x_next = f_axis(box_x_q, dir_x_q, c_x_lim);
        w_y_next = f_axis(box_y_q, dir_y_q, c_y_lim);

        mode_pend_d = mode_pend_q + {1'b0, mode_btn};
        mode_act_d  = w_tick ? mode_pend_q : mode_act_q;

        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;
        if (w_tick) begin
            {dir_x_d, box_x_d} = w_x_next;
            {dir_y_d, box_y_d} = w_y_next;
        end
    end

    // Pattern class is a {R,G,B} on/off triple; every colour used is full-scale.
    always_comb begin
        w_col = {1'b0, column_addr};
        w_row = {1'b0, row_addr};

        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_col >= (12'(k) * c_bar_w)) w_bar_idx = 3'(k);
        end

        case (w_bar_idx)
            3'd0:    w_bar_cls = 3'b111;
            3'd1:    w_bar_cls = 3'b110;
            3'd2:    w_bar_cls = 3'b011;
            3'd3:    w_bar_cls = 3'b010;
            3'd4:    w_bar_cls = 3'b101;
            3'd5:    w_bar_cls = 3'b100;
            3'd6:    w_bar_cls = 3'b001;
            default: w_bar_cls = 3'b000;
        endcase

        w_in_box = (w_col >= {1'b0, box_x_q}) && (w_col < ({1'b0, box_x_q} + c_size)) &&
                   (w_row >= {1'b0, box_y_q}) && (w_row < ({1'b0, box_y_q} + c_size));

        w_on_border = (w_col == 12'd0) || (w_col == c_h_last) ||
                      (w_row == 12'd0) || (w_row == c_v_last);

        case (mode_act_q)
            c_mode_bars:   cls_s1_d = w_bar_cls;
            c_mode_check:  cls_s1_d = {3{column_addr[5] ^ row_addr[5]}};
            c_mode_box:    cls_s1_d = w_in_box ? 3'b111 : 3'b001;
            c_mode_border: cls_s1_d = {3{w_on_border}};
            default:       cls_s1_d = 3'b000;
        endcase

        ready_s1_d = ready;
        hs_s1_d    = hsync_in;
        vs_s1_d    = vsync_in;

        red_d   = (ready_s1_q && cls_s1_q[2]) ? 5'd31 : 5'd0;
        green_d = (ready_s1_q && cls_s1_q[1]) ? 6'd63 : 6'd0;
        blue_d  = (ready_s1_q && cls_s1_q[0]) ? 5'd31 : 5'd0;
        hs_s2_d = hs_s1_q;
        vs_s2_d = vs_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_pend_q <= 2'd0;
            mode_act_q  <= 2'd0;
            box_x_q     <= 11'd0;
            box_y_q     <= 11'd0;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            ready_s1_q  <= 1'b0;
            cls_s1_q    <= 3'd0;
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            red_q       <= 5'd0;
            green_q     <= 6'd0;
            blue_q      <= 5'd0;
            hs_s2_q     <= 1'b1;
            vs_s2_q     <= 1'b1;
        end else begin
            mode_pend_q <= mode_pend_d;
            mode_act_q  <= mode_act_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            ready_s1_q  <= ready_s1_d;
            cls_s1_q    <= cls_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hs_s2_q     <= hs_s2_d;
            vs_s2_q     <= vs_s2_d;
        end
    end

    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign hsync_out = hs_s2_q;
    assign vsync_out = vs_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_ctrl
// Brief    : Directed self-checking bench for vga_pattern_ctrl.
// Revision : 1.0
// ============================================================================
module tb_vga_pattern_ctrl;

    localparam logic [15:0] c_white   = 16'hFFFF;
    localparam logic [15:0] c_yellow  = 16'hFFE0;
    localparam logic [15:0] c_magenta = 16'hF81F;
    localparam logic [15:0] c_blue    = 16'h001F;
    localparam logic [15:0] c_black   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [10:0] column_addr;
    logic [10:0] row_addr;
    logic        hsync_in;
    logic        vsync_in;
    logic        mode_btn;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        hsync_out;
    logic        vsync_out;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pattern_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .column_addr (column_addr),
        .row_addr    (row_addr),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .mode_btn    (mode_btn),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input logic rdy, input int col, input int row,
                       input logic [15:0] exp);
        ready       = rdy;
        column_addr = 11'(col);
        row_addr    = 11'(row);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq(tag, {16'd0, red, green, blue}, {16'd0, exp});
    endtask

    task automatic frame_tick();
        vsync_in = 1'b0;
        @(posedge clk); #1;
        vsync_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic press();
        mode_btn = 1'b1;
        @(posedge clk); #1;
        mode_btn = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [1:0] sync_pat [12];
    logic [1:0] prev;

    initial begin
        rst = 1'b1; ready = 1'b0; column_addr = '0; row_addr = '0;
        hsync_in = 1'b1; vsync_in = 1'b1; mode_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_rgb", {16'd0, red, green, blue}, 32'd0);
        check_eq("reset_sync", {30'd0, hsync_out, vsync_out}, 32'd3);
        rst = 1'b0;

        // Mode 0 colour bars (box stays at tick count T = 0 so far)
        pix("bar_c0",   1'b1,   0, 10, c_white);
        pix("bar_c99",  1'b1,  99, 10, c_white);
        pix("bar_c100", 1'b1, 100, 10, c_yellow);
        pix("bar_c150", 1'b1, 150, 10, c_yellow);
        pix("bar_c450", 1'b1, 450, 10, c_magenta);
        pix("bar_c699", 1'b1, 699, 10, c_blue);
        pix("bar_c700", 1'b1, 700, 10, c_black);
        pix("bar_c799", 1'b1, 799, 10, c_black);

        // Two presses mid-frame: no change until the tick
        press();
        press();
        pix("defer_mode0", 1'b1, 150, 10, c_yellow);
        frame_tick();                                   // T=1, mode 2, box (2,2)
        pix("box_in",     1'b1,  2,  2, c_white);
        pix("box_left",   1'b1,  1,  2, c_blue);
        pix("box_right",  1'b1, 65,  2, c_white);
        pix("box_rpast",  1'b1, 66,  2, c_blue);
        pix("box_below",  1'b1,  2, 66, c_blue);
        pix("box_noready",1'b0,  2,  2, c_black);

        // Tick and press together: act takes pre-increment pend (2)
        vsync_in = 1'b0; mode_btn = 1'b1;
        @(posedge clk); #1;
        vsync_in = 1'b1; mode_btn = 1'b0;
        @(posedge clk); #1;                             // T=2, box (4,4)
        pix("same_cyc_in",   1'b1, 4, 4, c_white);
        pix("same_cyc_left", 1'b1, 3, 4, c_blue);
        frame_tick();                                   // T=3, mode 3
        pix("brd_c0",    1'b1,   0, 300, c_white);
        pix("brd_c799",  1'b1, 799,   5, c_white);
        pix("brd_r0",    1'b1,   5,   0, c_white);
        pix("brd_r599",  1'b1,   5, 599, c_white);
        pix("brd_mid",   1'b1, 400, 300, c_black);
        pix("brd_inner", 1'b1, 798, 598, c_black);

        // Wrap 3 -> 0 -> 1
        press();
        press();
        frame_tick();                                   // T=4, mode 1
        pix("chk_32_0",   1'b1, 32,  0, c_white);
        pix("chk_32_32",  1'b1, 32, 32, c_black);
        pix("chk_64_32",  1'b1, 64, 32, c_white);
        pix("chk_31_31",  1'b1, 31, 31, c_black);
        pix("chk_noready",1'b0, 32,  0, c_black);

        press();
        frame_tick();                                   // T=5, mode 2
        repeat (263) frame_tick();                      // T=268, box (536,536), y flips
        pix("y_clamp_above", 1'b1, 540, 535, c_blue);
        pix("y_clamp_top",   1'b1, 540, 536, c_white);
        pix("y_clamp_far",   1'b1, 599, 599, c_white);
        pix("y_clamp_xleft", 1'b1, 535, 540, c_blue);
        repeat (100) frame_tick();                      // T=368, box (736,336)
        pix("x_clamp_left",  1'b1, 735, 336, c_blue);
        pix("x_clamp_edge",  1'b1, 736, 336, c_white);
        pix("x_clamp_last",  1'b1, 799, 336, c_white);
        pix("x_clamp_above", 1'b1, 736, 335, c_blue);
        frame_tick();                                   // T=369, box (734,334)
        pix("x_back_left",   1'b1, 733, 334, c_blue);
        pix("x_back_edge",   1'b1, 734, 334, c_white);
        pix("x_back_far",    1'b1, 797, 397, c_white);
        pix("x_back_right",  1'b1, 798, 334, c_blue);

        // Sync pass-through, two-clock delay
        sync_pat = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01,
                     2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
        prev = {hsync_in, vsync_in};
        for (int i = 0; i < 12; i++) begin
            {hsync_in, vsync_in} = sync_pat[i];
            column_addr = 11'(i * 37);
            row_addr    = 11'(i * 53);
            ready       = i[0];
            @(posedge clk); #1;
            check_eq("sync_delay", {30'd0, hsync_out, vsync_out}, {30'd0, prev});
            prev = sync_pat[i];
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // pend is 2 here; one press -> 3, then tick into border mode
        press();
        frame_tick();
        pix("pre_rst_border", 1'b1, 0, 300, c_white);

        // Mid-line reset
        hsync_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_rgb",  {16'd0, red, green, blue}, 32'd0);
        check_eq("rst_sync", {30'd0, hsync_out, vsync_out}, 32'd3);
        hsync_in = 1'b1;
        rst = 1'b0;
        pix("rst_mode0", 1'b1, 150, 10, c_yellow);
        press();
        press();
        frame_tick();                                   // box from (0,0) to (2,2)
        pix("rst_box_in",   1'b1,  2, 2, c_white);
        pix("rst_box_left", 1'b1,  1, 2, c_blue);
        pix("rst_box_rpast",1'b1, 66, 2, c_blue);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
